// File: rtl/paralelo_serial_param_if.sv
// Bus bundle for paralelo_serial_param: parallel word input handshake plus
// serial output, current-frame word and frame status.
interface paralelo_serial_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             data_out;
    logic [WIDTH-1:0] data2send;
    logic             active_out;
    logic             frame_start;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out,
        input  data2send,
        input  active_out,
        input  frame_start
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out,
        output data2send,
        output active_out,
        output frame_start
    );
endinterface

// File: rtl/paralelo_serial_param.sv
// Parametrised parallel-to-serial serialiser for the PCIe PHY transmit path.
// Words are queued in a DEPTH-entry FIFO and shifted out one bit per clock;
// IDLE_WORD frames fill the line when nothing is queued and during the
// start-up synchronisation phase.
// Optional feature macro: PARALELO_SERIAL_PARITY_EN appends an even-parity
// bit to every frame (data and idle).
module paralelo_serial_param #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(8'hBC),
    parameter int               SYNC_FRAMES = 4,
    parameter bit               MSB_FIRST   = 1'b1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    paralelo_serial_param_if.slave bus
);

`ifdef PARALELO_SERIAL_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FRAME);
    localparam int IW = $clog2(WIDTH);
    localparam int SW = $clog2(SYNC_FRAMES + 1);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
    // Index of the next bit to drive; wraps to 0 once the last bit of the
    // frame is on data_out, which marks the next edge as a load edge.
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             ready_q, ready_d;
    logic             dout_q, dout_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             active_q, active_d;
    logic             fs_q, fs_d;
    logic             full_d;
    logic             load_s;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;

    function automatic logic [WIDTH-1:0] reverse_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = w[WIDTH-1-i];
        end
        return r;
    endfunction

`ifdef PARALELO_SERIAL_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    // Bit idx of the frame for word w, honouring bit order and parity slot.
    function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
        logic [WIDTH-1:0] ordered;
        logic             b;
        ordered = MSB_FIRST ? reverse_word(w) : w;
`ifdef PARALELO_SERIAL_PARITY_EN
        if (idx == CW'(WIDTH)) begin
            b = even_parity(w);
        end else begin
            b = ordered[idx[IW-1:0]];
        end
`else
        b = ordered[idx[IW-1:0]];
`endif
        return b;
    endfunction

    assign load_s  = (bit_cnt_q == CW'(0));
    assign push_s  = bus.valid_in & ready_q;
    assign empty_s = (wr_q == rd_q);

    // Next-state: FSM, frame sequencing, word selection and FIFO occupancy.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        active_d   = active_q;
        dout_d     = dout_q;
        fs_d       = 1'b0;
        pop_s      = 1'b0;
        if (load_s) begin
            fs_d      = 1'b1;
            bit_cnt_d = CW'(1);
            case (state_q)
                ST_SYNC: begin
                    word_d   = IDLE_WORD;
                    active_d = 1'b0;
                    if (sync_cnt_q == SW'(SYNC_FRAMES)) begin
                        state_d = ST_RUN;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        word_d   = mem_q[rd_q[AW-1:0]];
                        active_d = 1'b1;
                    end else begin
                        word_d   = IDLE_WORD;
                        active_d = 1'b0;
                    end
                end
                default: begin
                    state_d  = ST_SYNC;
                    word_d   = IDLE_WORD;
                    active_d = 1'b0;
                end
            endcase
            dout_d = pick_bit(word_d, CW'(0));
        end else begin
            dout_d = pick_bit(word_q, bit_cnt_q);
            if (bit_cnt_q == CW'(FRAME - 1)) begin
                bit_cnt_d = CW'(0);
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
        if (push_s) begin
            wr_d = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
        full_d  = ((wr_d ^ rd_d) == {1'b1, {AW{1'b0}}});
        ready_d = (state_d == ST_RUN) && !full_d;
    end

    // State, counters, FIFO pointers and registered outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= ST_SYNC;
            sync_cnt_q <= '0;
            bit_cnt_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            ready_q    <= 1'b0;
            dout_q     <= 1'b0;
            word_q     <= '0;
            active_q   <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            word_q     <= word_d;
            active_q   <= active_d;
            fs_q       <= fs_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers are reset.
    always_ff @(posedge clk_32f) begin
        if (push_s) begin
            mem_q[wr_q[AW-1:0]] <= bus.data_in;
        end
    end

    assign bus.ready_out   = ready_q;
    assign bus.data_out    = dout_q;
    assign bus.data2send   = word_q;
    assign bus.active_out  = active_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Self-checking bench for paralelo_serial_param: directed corner cases plus
// randomized traffic compared against a queue-based reference model.
module tb_paralelo_serial_param;

    localparam int         W0    = 8;
    localparam int         D0    = 4;
    localparam int         S0    = 4;
    localparam logic [7:0] IDLE0 = 8'hBC;
`ifdef PARALELO_SERIAL_PARITY_EN
    localparam int F0 = W0 + 1;
    localparam int F1 = 11;
`else
    localparam int F0 = W0;
    localparam int F1 = 10;
`endif

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       exp_dout;
        logic       exp_fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   total = 0;
    int   bad   = 0;

    // reference model state
    logic [7:0] m_q[$];
    int         m_phase;
    int         m_frames;
    logic       m_ready, m_dout, m_active, m_fs;
    logic [7:0] m_word;

    always #5 clk = ~clk;

    paralelo_serial_param_if #(.WIDTH(8))  bus0 ();
    paralelo_serial_param_if #(.WIDTH(10)) bus1 ();

    paralelo_serial_param #(.WIDTH(8), .DEPTH(4), .IDLE_WORD(8'hBC),
                            .SYNC_FRAMES(4), .MSB_FIRST(1'b1))
        u0 (.clk_32f(clk), .reset(rst0), .bus(bus0));

    paralelo_serial_param #(.WIDTH(10), .DEPTH(2), .IDLE_WORD(10'h17C),
                            .SYNC_FRAMES(2), .MSB_FIRST(1'b0))
        u1 (.clk_32f(clk), .reset(rst1), .bus(bus1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit k of an MSB-first frame of w; position W0 is the even-parity bit.
    function automatic logic ref_bit(input logic [7:0] w, input int k);
        logic [7:0] t;
        if (k >= W0) return ^w;
        t = w << k;
        return t[7];
    endfunction

    // One clock of u0: drive inputs, advance the model, compare outputs.
    task automatic tick(input logic r, input logic v, input logic [7:0] d);
        logic push;
        rst0          = r;
        bus0.valid_in = v;
        bus0.data_in  = d;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_phase  = 0;
            m_frames = 0;
            m_ready  = 1'b0;
            m_dout   = 1'b0;
            m_active = 1'b0;
            m_fs     = 1'b0;
            m_word   = 8'h00;
        end else begin
            push = v && m_ready;
            m_fs = (m_phase == 0);
            if (m_fs) begin
                m_frames++;
                if (m_frames >= S0 + 2 && m_q.size() > 0) begin
                    m_word   = m_q.pop_front();
                    m_active = 1'b1;
                end else begin
                    m_word   = IDLE0;
                    m_active = 1'b0;
                end
            end
            m_dout = ref_bit(m_word, m_phase);
            if (push) m_q.push_back(d);
            m_phase = (m_phase + 1) % F0;
            m_ready = (m_frames >= S0 + 1) && (m_q.size() < D0);
        end
        #1;
        chk("data_out",    bus0.data_out,    m_dout);
        chk("frame_start", bus0.frame_start, m_fs);
        chk("active_out",  bus0.active_out,  m_active);
        chk("ready_out",   bus0.ready_out,   m_ready);
        chk("data2send",   bus0.data2send,   m_word);
    endtask

    // Idle clocks until a frame starts; the tick that shows frame_start is the last.
    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end while (bus0.frame_start !== 1'b1 && n < budget);
        chk("wait_fs_timeout", bus0.frame_start, 1'b1);
    endtask

    initial begin
        vec_t       t1[8];
        vec_t       t6[F1];
        logic [7:0] idle_bits;
        logic [9:0] idle1;
        logic [7:0] got;
        int         n;
        int         acc;
        int         dens;

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.valid_in = 1'b0;
        bus0.data_in  = 8'h00;
        bus1.valid_in = 1'b0;
        bus1.data_in  = 10'h000;

        // vector tables
        idle_bits = IDLE0;
        for (int i = 0; i < 8; i++) begin
            t1[i] = '{1'b0, 8'h00, idle_bits[7-i], (i == 0)};
        end
        idle1 = 10'h17C;
        for (int i = 0; i < F1; i++) begin
            t6[i] = '{1'b0, 8'h00, (i < 10) ? idle1[i] : ^idle1, (i == 0)};
        end

        // 1: reset for 3 cycles, then sync-phase idle frames
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        chk("rst_data_out",  bus0.data_out,    1'b0);
        chk("rst_data2send", bus0.data2send,   8'h00);
        chk("rst_ready",     bus0.ready_out,   1'b0);
        chk("rst_active",    bus0.active_out,  1'b0);
        chk("rst_fs",        bus0.frame_start, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, t1[i].v, t1[i].d);
            chk("t1_bit", bus0.data_out,    t1[i].exp_dout);
            chk("t1_fs",  bus0.frame_start, t1[i].exp_fs);
        end
        for (int c = 8; c < S0 * F0; c++) begin
            tick(1'b0, 1'b0, 8'h00);
            chk("t1_ready_sync", bus0.ready_out, 1'b0);
        end
        tick(1'b0, 1'b0, 8'h00);
        chk("t1_frame5_fs",    bus0.frame_start, 1'b1);
        chk("t1_frame5_ready", bus0.ready_out,   1'b1);

        // 2: single word A5
        tick(1'b0, 1'b1, 8'hA5);
        wait_fs(F0 + 2);
        chk("t2_word",   bus0.data2send,  8'hA5);
        chk("t2_active", bus0.active_out, 1'b1);
        got = {7'h00, bus0.data_out};
        for (int k = 1; k < 8; k++) begin
            tick(1'b0, 1'b0, 8'h00);
            got = {got[6:0], bus0.data_out};
        end
        chk("t2_serial", got, 8'hA5);
        wait_fs(F0 + 2);
        chk("t2_idle_word",   bus0.data2send,  IDLE0);
        chk("t2_idle_active", bus0.active_out, 1'b0);

        // 3: fill FIFO, fifth word waits for a pop
        for (int k = 1; k <= 4; k++) tick(1'b0, 1'b1, 8'(k));
        chk("t3_full_ready", bus0.ready_out, 1'b0);
        n = 0;
        while (bus0.ready_out !== 1'b1 && n < 2 * F0) begin
            tick(1'b0, 1'b1, 8'h05);
            n++;
        end
        chk("t3_pop_fs",   bus0.frame_start, 1'b1);
        chk("t3_pop_word", bus0.data2send,   8'h01);
        tick(1'b0, 1'b1, 8'h05);
        chk("t3_full_again", bus0.ready_out, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            wait_fs(F0 + 2);
            chk("t3_order", bus0.data2send, 8'(k));
        end
        wait_fs(F0 + 2);
        chk("t3_drained", bus0.active_out, 1'b0);

        // 4: push on the same edge as a pop with 3 queued
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        tick(1'b0, 1'b1, 8'h33);
        repeat (F0 - 4) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h44);
        chk("t4_load_fs",   bus0.frame_start, 1'b1);
        chk("t4_load_word", bus0.data2send,   8'h11);
        chk("t4_ready_3",   bus0.ready_out,   1'b1);
        acc = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus0.ready_out === 1'b1) acc++;
            tick(1'b0, 1'b1, 8'h55 + 8'(k));
        end
        chk("t4_room_left", acc, 1);
        for (int k = 0; k < 4; k++) begin
            wait_fs(F0 + 2);
            chk("t4_order", bus0.data2send, 8'h22 + 8'h11 * 8'(k));
        end
        wait_fs(F0 + 2);
        chk("t4_drained", bus0.active_out, 1'b0);

        // 5: reset mid-frame with two words queued
        tick(1'b0, 1'b1, 8'h66);
        tick(1'b0, 1'b1, 8'h77);
        tick(1'b1, 1'b0, 8'h00);
        chk("t5_dout",   bus0.data_out,    1'b0);
        chk("t5_word",   bus0.data2send,   8'h00);
        chk("t5_ready",  bus0.ready_out,   1'b0);
        chk("t5_active", bus0.active_out,  1'b0);
        chk("t5_fs",     bus0.frame_start, 1'b0);
        for (int c = 0; c < (S0 + 2) * F0; c++) begin
            tick(1'b0, 1'b0, 8'h00);
            chk("t5_no_data", bus0.active_out, 1'b0);
            if (c == S0 * F0 - 1) chk("t5_sync_ready", bus0.ready_out, 1'b0);
            if (c == S0 * F0)     chk("t5_run_ready",  bus0.ready_out, 1'b1);
        end

        // 6: LSB-first 10-bit instance
        rst1 = 1'b0;
        for (int i = 0; i < F1; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            chk("t6_bit", bus1.data_out,    t6[i].exp_dout);
            chk("t6_fs",  bus1.frame_start, t6[i].exp_fs);
            if (i == 0) chk("t6_word", bus1.data2send, 10'h17C);
        end
        tick(1'b0, 1'b0, 8'h00);
        chk("t6_next_fs", bus1.frame_start, 1'b1);

        // randomized traffic with occasional resets
        dens = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dens = int'($urandom_range(10, 95));
            tick(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                 (int'($urandom_range(0, 99)) < dens) ? 1'b1 : 1'b0,
                 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
